// File: rtl/multi_sram_rd_ctrl.sv
// Burst read sequencer for SRAM port B: issues one read per cycle, absorbs the 1-cycle
// read latency and returns words through a 2-entry FIFO. Optional range check: MULTI_SRAM_RD_CHK_EN.
module multi_sram_rd_ctrl #(
  parameter int DWIDTH    = 32,
  parameter int NRAMWIDTH = 5,
  parameter int AWIDTH    = 13,
  parameter int NRAM      = 32,
  parameter int LWIDTH    = 8
) (
  input  logic                        clk_in,
  input  logic                        rst_n_in,
  input  logic                        cmd_valid_in,
  output logic                        cmd_ready_out,
  input  logic [NRAMWIDTH+AWIDTH-1:0] cmd_addr_in,
  input  logic [LWIDTH-1:0]           cmd_len_in,
  output logic                        en_b_out,
  output logic                        we_b_out,
  output logic [NRAMWIDTH+AWIDTH-1:0] addr_b_out,
  input  logic [DWIDTH-1:0]           d_b_in,
  output logic                        rd_valid_out,
  input  logic                        rd_ready_in,
  output logic [DWIDTH-1:0]           rd_data_out,
  output logic                        rd_last_out,
  output logic                        done_out,
  output logic                        err_out,
  output logic [1:0]                  state_dbg_out
);

  localparam int FW = NRAMWIDTH + AWIDTH;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  if (NRAM < 1 || NRAM > (1 << NRAMWIDTH)) begin : g_nram_range
    $error("NRAM out of range for NRAMWIDTH");
  end

  // Handshakes: a command transfers on cmd_valid_in & cmd_ready_out, a word transfers on
  // rd_valid_out & rd_ready_in; a presented word stays stable until it transfers.

  logic [1:0]        state_q;
  logic [FW-1:0]     addr_q;
  logic [LWIDTH-1:0] rem_q;
  logic              inflight_q;
  logic              inflight_last_q;
  logic [DWIDTH-1:0] buf_data_q [2];
  logic [1:0]        buf_last_q;
  logic              rd_ptr_q;
  logic              wr_ptr_q;
  logic [1:0]        cnt_q;
  logic              done_q;
  logic              err_q;

  logic       cmd_fire;
  logic       pop;
  logic       head_last;
  logic [1:0] occ;
  logic       issue;
  logic       reject;

  assign cmd_ready_out = (state_q == ST_IDLE);
  assign cmd_fire      = cmd_valid_in && cmd_ready_out;
  assign rd_valid_out  = (cnt_q != 2'd0);
  assign pop           = rd_valid_out && rd_ready_in;
  assign head_last     = buf_last_q[rd_ptr_q];
  // The in-flight read already owns a buffer slot, so it is counted before issuing.
  assign occ           = cnt_q + {1'b0, inflight_q};
  assign issue         = (state_q == ST_ISSUE) && (rem_q != '0) && ((occ < 2'd2) || pop);

`ifdef MULTI_SRAM_RD_CHK_EN
  localparam int EW = FW + LWIDTH + 1;
  localparam logic [EW-1:0] LIMIT = EW'(NRAM) << AWIDTH;
  logic [EW-1:0] end_addr;
  logic          bank_bad;
  assign end_addr = EW'(cmd_addr_in) + EW'(cmd_len_in) - EW'(1);
  assign bank_bad = EW'(cmd_addr_in[FW-1:AWIDTH]) >= EW'(NRAM);
  assign reject   = bank_bad || ((cmd_len_in != '0) && (end_addr >= LIMIT));
`else
  assign reject   = 1'b0;
`endif

  assign en_b_out      = issue;
  assign we_b_out      = 1'b0;
  assign addr_b_out    = addr_q;
  assign rd_data_out   = rd_valid_out ? buf_data_q[rd_ptr_q] : '0;
  assign rd_last_out   = rd_valid_out && head_last;
  assign done_out      = done_q;
  assign err_out       = err_q;
  assign state_dbg_out = state_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      rem_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      buf_last_q      <= '0;
      rd_ptr_q        <= 1'b0;
      wr_ptr_q        <= 1'b0;
      cnt_q           <= 2'd0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      done_q          <= 1'b0;
      err_q           <= 1'b0;
      inflight_q      <= issue;
      inflight_last_q <= issue && (rem_q == LWIDTH'(1));

      if (inflight_q) begin
        buf_last_q[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({inflight_q, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase

      case (state_q)
        ST_IDLE: begin
          if (cmd_fire) begin
            if (reject) begin
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else if (cmd_len_in == '0) begin
              done_q <= 1'b1;
            end else begin
              addr_q  <= cmd_addr_in;
              rem_q   <= cmd_len_in;
              state_q <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (issue) begin
            addr_q <= addr_q + FW'(1);
            rem_q  <= rem_q - LWIDTH'(1);
            if (rem_q == LWIDTH'(1)) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (pop && head_last) begin
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Data slots carry no reset; they are only observed behind rd_valid_out.
  always_ff @(posedge clk_in) begin
    if (inflight_q) buf_data_q[wr_ptr_q] <= d_b_in;
  end

endmodule

// File: tb/tb_multi_sram_rd_ctrl.sv
// Testbench for multi_sram_rd_ctrl: SRAM model, directed bursts plus random bursts with
// random backpressure, scoreboard over read addresses and returned words.
module tb_multi_sram_rd_ctrl;

  localparam int DW = 32;
  localparam int NW = 5;
  localparam int AW = 13;
  localparam int LW = 8;
  localparam int FW = NW + AW;

  logic          clk;
  logic          rst_n;
  logic          cmd_valid_in;
  logic          cmd_ready_out;
  logic [FW-1:0] cmd_addr_in;
  logic [LW-1:0] cmd_len_in;
  logic          en_b_out;
  logic          we_b_out;
  logic [FW-1:0] addr_b_out;
  logic [DW-1:0] d_b_in;
  logic          rd_valid_out;
  logic          rd_ready_in;
  logic [DW-1:0] rd_data_out;
  logic          rd_last_out;
  logic          done_out;
  logic          err_out;
  logic [1:0]    state_dbg_out;

  multi_sram_rd_ctrl #(
    .DWIDTH(DW), .NRAMWIDTH(NW), .AWIDTH(AW), .NRAM(32), .LWIDTH(LW)
  ) dut (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .cmd_valid_in  (cmd_valid_in),
    .cmd_ready_out (cmd_ready_out),
    .cmd_addr_in   (cmd_addr_in),
    .cmd_len_in    (cmd_len_in),
    .en_b_out      (en_b_out),
    .we_b_out      (we_b_out),
    .addr_b_out    (addr_b_out),
    .d_b_in        (d_b_in),
    .rd_valid_out  (rd_valid_out),
    .rd_ready_in   (rd_ready_in),
    .rd_data_out   (rd_data_out),
    .rd_last_out   (rd_last_out),
    .done_out      (done_out),
    .err_out       (err_out),
    .state_dbg_out (state_dbg_out)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- SRAM model and expectations ----------------
  function automatic logic [DW-1:0] mem_word(input logic [FW-1:0] a);
    return ({14'd0, a} * 32'h9E37_79B1) ^ 32'hC3A5_0000;
  endfunction

  initial d_b_in = '0;
  always @(posedge clk) begin
    if (en_b_out) d_b_in <= mem_word(addr_b_out);
  end

  logic [DW:0]   exp_q[$];
  logic [FW-1:0] exp_addr_q[$];
  int            exp_done;
  int            done_cnt;
  int            en_cnt;
  int            n_checks;
  int            n_pass;
  int            ready_mode;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- downstream ready driver ----------------
  initial begin
    rd_ready_in = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       rd_ready_in = 1'b1;
        1:       rd_ready_in = 1'b0;
        default: rd_ready_in = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic        prev_hold;
  logic [DW:0] prev_word;
  initial begin
    prev_hold = 1'b0;
    prev_word = '0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (en_b_out) begin
        en_cnt++;
        chk("we_b_low", {63'd0, we_b_out}, 64'd0);
        if (exp_addr_q.size() == 0) chk("unexpected_read", {63'd0, en_b_out}, 64'd0);
        else chk("read_addr", {46'd0, addr_b_out}, {46'd0, exp_addr_q.pop_front()});
      end
      if (prev_hold) begin
        chk("hold_valid", {63'd0, rd_valid_out}, 64'd1);
        chk("hold_word", {31'd0, rd_last_out, rd_data_out}, {31'd0, prev_word});
      end
      if (rd_valid_out && rd_ready_in) begin
        if (exp_q.size() == 0) chk("unexpected_word", {63'd0, rd_valid_out}, 64'd0);
        else chk("rd_word", {31'd0, rd_last_out, rd_data_out}, {31'd0, exp_q.pop_front()});
      end
      if (done_out) begin
        done_cnt++;
        chk("err_with_done", {63'd0, err_out}, 64'd0);
      end
      prev_hold = rd_valid_out && !rd_ready_in;
      prev_word = {rd_last_out, rd_data_out};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [FW-1:0] a, input logic [LW-1:0] l);
    int t = 0;
    while (!cmd_ready_out && t < 1000) begin
      cycle();
      t++;
    end
    chk("cmd_ready_wait", {63'd0, cmd_ready_out}, 64'd1);
    for (int i = 0; i < int'(l); i++) begin
      exp_addr_q.push_back(a + FW'(i));
      exp_q.push_back({(i == int'(l) - 1), mem_word(a + FW'(i))});
    end
    exp_done++;
    cmd_addr_in  = a;
    cmd_len_in   = l;
    cmd_valid_in = 1'b1;
    cycle();
    cmd_valid_in = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!(exp_q.size() == 0 && exp_addr_q.size() == 0 && done_cnt == exp_done) && t < 3000) begin
      cycle();
      t++;
    end
    chk("words_left", 64'(exp_q.size()), 64'd0);
    chk("done_count", 64'(done_cnt), 64'(exp_done));
    repeat (3) cycle();
    chk("no_extra_done", 64'(done_cnt), 64'(exp_done));
    chk("idle_ready", {63'd0, cmd_ready_out}, 64'd1);
  endtask

  // ---------------- stimulus ----------------
  logic [8:0] en_m, v_m, d_m;
  int         en0;

  initial begin
    n_checks = 0; n_pass = 0; exp_done = 0; done_cnt = 0; en_cnt = 0;
    ready_mode = 0;
    rst_n = 1'b0; cmd_valid_in = 1'b0; cmd_addr_in = '0; cmd_len_in = '0;
    repeat (3) cycle();
    chk("rst_cmd_ready", {63'd0, cmd_ready_out}, 64'd1);
    chk("rst_en_b", {63'd0, en_b_out}, 64'd0);
    chk("rst_addr_b", {46'd0, addr_b_out}, 64'd0);
    chk("rst_rd_valid", {63'd0, rd_valid_out}, 64'd0);
    chk("rst_rd_word", {31'd0, rd_last_out, rd_data_out}, 64'd0);
    chk("rst_done_err", {62'd0, done_out, err_out}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    // Basic burst: exact cycle timing of reads, words and done.
    en_m = '0; v_m = '0; d_m = '0;
    send_cmd(18'h00010, 8'd4);
    for (int k = 1; k <= 8; k++) begin
      en_m[k] = en_b_out;
      v_m[k]  = rd_valid_out;
      d_m[k]  = done_out;
      cycle();
    end
    chk("t1_en_timing", {55'd0, en_m}, 64'b0_0001_1110);
    chk("t1_valid_timing", {55'd0, v_m}, 64'b0_0111_1000);
    chk("t1_done_timing", {55'd0, d_m}, 64'b0_1000_0000);
    wait_idle();

    // Backpressure: only two reads may be outstanding.
    ready_mode = 1;
    repeat (2) cycle();
    en0 = en_cnt;
    send_cmd(18'h00100, 8'd3);
    repeat (10) cycle();
    chk("t2_stalled_issues", 64'(en_cnt - en0), 64'd2);
    chk("t2_word_waiting", {63'd0, rd_valid_out}, 64'd1);
    ready_mode = 0;
    wait_idle();
    chk("t2_total_issues", 64'(en_cnt - en0), 64'd3);

    // Bank carry and top-of-space wrap.
    ready_mode = 2;
    send_cmd(18'h05FFF, 8'd2);
    wait_idle();
    send_cmd(18'h3FFFF, 8'd2);
    wait_idle();

    // Empty burst followed immediately by another command.
    ready_mode = 0;
    repeat (2) cycle();
    en0 = en_cnt;
    send_cmd(18'h00200, 8'd0);
    chk("t4_done_pulse", {63'd0, done_out}, 64'd1);
    chk("t4_err_low", {63'd0, err_out}, 64'd0);
    chk("t4_ready_again", {63'd0, cmd_ready_out}, 64'd1);
    send_cmd(18'h00300, 8'd2);
    wait_idle();
    chk("t4_issues", 64'(en_cnt - en0), 64'd2);

    // Reset mid-burst with data buffered.
    ready_mode = 1;
    repeat (2) cycle();
    send_cmd(18'h01000, 8'd8);
    begin
      int t = 0;
      while (!rd_valid_out && t < 20) begin
        cycle();
        t++;
      end
    end
    chk("t5_buffered", {63'd0, rd_valid_out}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", {63'd0, rd_valid_out}, 64'd0);
    chk("t5_rst_ready", {63'd0, cmd_ready_out}, 64'd1);
    chk("t5_rst_en_done", {62'd0, en_b_out, done_out}, 64'd0);
    chk("t5_rst_word", {31'd0, rd_last_out, rd_data_out}, 64'd0);
    exp_q.delete();
    exp_addr_q.delete();
    exp_done = done_cnt;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ready_mode = 2;
    cycle();
    send_cmd(18'h02000, 8'd5);
    wait_idle();

    // Random bursts, back to back, random backpressure.
    for (int n = 0; n < 25; n++) begin
      logic [FW-1:0] a;
      logic [LW-1:0] l;
      a = FW'($urandom_range(0, (1 << FW) - 1));
      l = ($urandom_range(0, 7) == 0) ? 8'd0 : LW'($urandom_range(1, 12));
      send_cmd(a, l);
    end
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
